// File: rtl/key_debounce_array.sv
// Multi-channel button debouncer with press/release/long-press pulses for the front panel.
// Define KEY_AUTO_REPEAT_EN to build the auto-repeat logic; otherwise repeat_pulse is tied to 0.
module key_debounce_array #(
    parameter int CHANNELS    = 4,
    parameter int TICK_CYCLES = 50000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter bit IDLE_LEVEL  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_state,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_event
);

    localparam int              PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [7:0]      DB_LAST  = 8'(DEBOUNCE_MS - 1);
    localparam logic [15:0]     LONG_H   = 16'(LONG_MS);

    if (DEBOUNCE_MS < 2 || DEBOUNCE_MS > 256 || LONG_MS <= DEBOUNCE_MS ||
        REPEAT_MS < 1 || TICK_CYCLES < 1) begin : g_param_check
        $error("key_debounce_array: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} key_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [PW-1:0]       pre_cnt;
    logic                tick;
    logic [CHANNELS-1:0] sync_p0, sync_p1, norm, norm_p2;
    logic [7:0]          db_cnt  [CHANNELS];
    logic [7:0]          db_nxt  [CHANNELS];
    logic [15:0]         h_cnt   [CHANNELS];
    logic [15:0]         h_nxt   [CHANNELS];
    key_state_t          fsm     [CHANNELS];
    key_state_t          fsm_nxt [CHANNELS];
    logic [CHANNELS-1:0] state_nxt, acc_press, acc_rel;
    logic [CHANNELS-1:0] press_nxt, release_nxt, long_nxt;
    logic                any_nxt;

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [15:0] REP_H = 16'(REPEAT_MS);
    logic [CHANNELS-1:0] repeat_nxt;
`else
    assign repeat_pulse = '0;
`endif

    assign tick = (pre_cnt == PRE_LAST);
    assign norm = sync_p1 ^ {CHANNELS{IDLE_LEVEL}};

    always_ff @(posedge clk) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    always_comb begin
        state_nxt   = button_state;
        acc_press   = '0;
        acc_rel     = '0;
        press_nxt   = '0;
        release_nxt = '0;
        long_nxt    = '0;
`ifdef KEY_AUTO_REPEAT_EN
        repeat_nxt  = '0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            db_nxt[i]  = db_cnt[i];
            h_nxt[i]   = h_cnt[i];
            fsm_nxt[i] = fsm[i];

            // Debounce: any disagreement must survive DEBOUNCE_MS ticks without a change.
            if (norm[i] == button_state[i] || norm[i] != norm_p2[i]) begin
                db_nxt[i] = 8'd0;
            end else if (tick) begin
                if (db_cnt[i] == DB_LAST) begin
                    db_nxt[i]    = 8'd0;
                    state_nxt[i] = norm[i];
                    acc_press[i] = norm[i];
                    acc_rel[i]   = ~norm[i];
                end else begin
                    db_nxt[i] = db_cnt[i] + 8'd1;
                end
            end

            if (acc_rel[i]) begin
                release_nxt[i] = 1'b1;
                h_nxt[i]       = 16'd0;
                fsm_nxt[i]     = S_IDLE;
            end else begin
                case (fsm[i])
                    S_IDLE: if (acc_press[i]) begin
                        press_nxt[i] = 1'b1;
                        h_nxt[i]     = 16'd0;
                        fsm_nxt[i]   = S_HELD;
                    end
                    S_HELD: if (tick) begin
                        if (sat_inc(h_cnt[i]) == LONG_H) begin
                            long_nxt[i] = 1'b1;
                            h_nxt[i]    = 16'd0;
                            fsm_nxt[i]  = S_LONG;
                        end else begin
                            h_nxt[i] = sat_inc(h_cnt[i]);
                        end
                    end
                    S_LONG: begin
`ifdef KEY_AUTO_REPEAT_EN
                        if (tick) begin
                            if (sat_inc(h_cnt[i]) == REP_H) begin
                                repeat_nxt[i] = 1'b1;
                                h_nxt[i]      = 16'd0;
                            end else begin
                                h_nxt[i] = sat_inc(h_cnt[i]);
                            end
                        end
`endif
                    end
                    default: fsm_nxt[i] = S_IDLE;
                endcase
            end
        end
`ifdef KEY_AUTO_REPEAT_EN
        any_nxt = |{press_nxt, release_nxt, long_nxt, repeat_nxt};
`else
        any_nxt = |{press_nxt, release_nxt, long_nxt};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0       <= {CHANNELS{IDLE_LEVEL}};
            sync_p1       <= {CHANNELS{IDLE_LEVEL}};
            norm_p2       <= '0;
            button_state  <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            any_event     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                db_cnt[i] <= 8'd0;
                h_cnt[i]  <= 16'd0;
                fsm[i]    <= S_IDLE;
            end
        end else begin
            sync_p0       <= button_in;
            sync_p1       <= sync_p0;
            norm_p2       <= norm;
            button_state  <= state_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            any_event     <= any_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                db_cnt[i] <= db_nxt[i];
                h_cnt[i]  <= h_nxt[i];
                fsm[i]    <= fsm_nxt[i];
            end
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) repeat_pulse <= '0;
        else     repeat_pulse <= repeat_nxt;
    end
`endif

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array with a 10-cycle tick, 4-tick debounce,
// 20-tick long press and 5-tick repeat; repeat checks follow KEY_AUTO_REPEAT_EN.
module tb_key_debounce_array;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] button_in = 4'hF;
    logic [CH-1:0] button_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic          any_event;

    key_debounce_array #(
        .CHANNELS(CH), .TICK_CYCLES(10), .DEBOUNCE_MS(4),
        .LONG_MS(20), .REPEAT_MS(5), .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .button_in(button_in),
        .button_state(button_state), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .any_event(any_event)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int press_cnt [CH];
    int rel_cnt   [CH];
    int long_cnt  [CH];
    int rep_cnt   [CH];
    int press_cyc [CH];
    int rel_cyc   [CH];
    int long_cyc  [CH];
    int rep_cyc   [CH];
    int any_bad = 0;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (press_pulse[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
            if (release_pulse[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
            if (long_pulse[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
            if (repeat_pulse[i])  begin rep_cnt[i]++;   rep_cyc[i]   = cyc; end
        end
        if (any_event !== (|{press_pulse, release_pulse, long_pulse, repeat_pulse}))
            any_bad++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int pb [CH];
    int rb [CH];
    int lb [CH];
    int qb [CH];

    task automatic snap();
        for (int i = 0; i < CH; i++) begin
            pb[i] = press_cnt[i]; rb[i] = rel_cnt[i];
            lb[i] = long_cnt[i];  qb[i] = rep_cnt[i];
        end
    endtask

    function automatic int in_win(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 1 : 0;
    endfunction

    int t0, lat, tot;

    initial begin
        // 1: long reset with all buttons released
        step(1000);
        check("rst button_state", int'(button_state), 0);
        check("rst pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        check("rst any_event", int'(any_event), 0);
        snap();
        rst = 1'b0;
        step(100);
        tot = 0;
        for (int i = 0; i < CH; i++)
            tot += (press_cnt[i]-pb[i]) + (rel_cnt[i]-rb[i]) + (long_cnt[i]-lb[i]) + (rep_cnt[i]-qb[i]);
        check("no pulses after reset", tot, 0);
        check("idle button_state", int'(button_state), 0);

        // 2: clean press and release on ch0
        snap();
        button_in[0] = 1'b0; t0 = cyc;
        step(300);
        check("ch0 press count", press_cnt[0]-pb[0], 1);
        lat = press_cyc[0] - t0;
        check($sformatf("ch0 press latency %0d in 30..44", lat), in_win(lat, 30, 44), 1);
        check("ch0 state pressed", int'(button_state[0]), 1);
        button_in[0] = 1'b1; t0 = cyc;
        step(100);
        check("ch0 release count", rel_cnt[0]-rb[0], 1);
        lat = rel_cyc[0] - t0;
        check($sformatf("ch0 release latency %0d in 30..44", lat), in_win(lat, 30, 44), 1);
        check("ch0 state released", int'(button_state[0]), 0);
        check("ch0 single press", press_cnt[0]-pb[0], 1);

        // 3: bouncing ch1, five toggles 15 cycles apart, ending pressed
        snap();
        for (int k = 0; k < 5; k++) begin
            button_in[1] = ~button_in[1];
            t0 = cyc;
            if (k < 4) step(15);
        end
        check("ch1 no press during bounce", press_cnt[1]-pb[1], 0);
        check("ch1 no release during bounce", rel_cnt[1]-rb[1], 0);
        step(60);
        check("ch1 press count", press_cnt[1]-pb[1], 1);
        lat = press_cyc[1] - t0;
        check($sformatf("ch1 press latency %0d in 30..44", lat), in_win(lat, 30, 44), 1);
        button_in[1] = 1'b1;
        step(60);
        check("ch1 release count", rel_cnt[1]-rb[1], 1);

        // 4: ch2 held for a long press, stays held into test 6
        snap();
        button_in[2] = 1'b0; t0 = cyc;
        step(400);
        check("ch2 press count", press_cnt[2]-pb[2], 1);
        check("ch2 long count", long_cnt[2]-lb[2], 1);
        lat = long_cyc[2] - press_cyc[2];
        check($sformatf("ch2 long delay %0d in 190..210", lat), in_win(lat, 190, 210), 1);
`ifdef KEY_AUTO_REPEAT_EN
        check("ch2 repeat count", rep_cnt[2]-qb[2], 3);
        check("ch2 last repeat offset", rep_cyc[2] - long_cyc[2], 150);
`else
        check("ch2 repeat stays 0", rep_cnt[2]-qb[2], 0);
`endif
        check("ch2 no release", rel_cnt[2]-rb[2], 0);

        // 5: ch0 and ch3 pressed together, then released together
        snap();
        button_in[0] = 1'b0; button_in[3] = 1'b0;
        step(60);
        check("ch0 press count sim", press_cnt[0]-pb[0], 1);
        check("ch3 press count sim", press_cnt[3]-pb[3], 1);
        check("ch0/ch3 press same cycle", press_cyc[0] - press_cyc[3], 0);
        button_in[0] = 1'b1; button_in[3] = 1'b1;
        step(60);
        check("ch0 release count sim", rel_cnt[0]-rb[0], 1);
        check("ch3 release count sim", rel_cnt[3]-rb[3], 1);
        check("ch0/ch3 release same cycle", rel_cyc[0] - rel_cyc[3], 0);

        // 6: one-cycle reset while ch2 is in LONG
        step(7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid reset state", int'(button_state), 0);
        check("mid reset pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        check("mid reset any_event", int'(any_event), 0);
        snap();
        t0 = cyc;
        step(60);
        check("ch2 re-press count", press_cnt[2]-pb[2], 1);
        lat = press_cyc[2] - t0;
        check($sformatf("ch2 re-press latency %0d in 30..44", lat), in_win(lat, 30, 44), 1);
        check("ch2 no release after reset", rel_cnt[2]-rb[2], 0);
        check("ch2 state after re-press", int'(button_state[2]), 1);
        button_in[2] = 1'b1;
        step(60);
        check("ch2 final release", rel_cnt[2]-rb[2], 1);
        check("any_event matches pulses", any_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
